sync_fifo: RTL

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered or first-word-fall-through read port,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int PTR_WIDTH = 3,
    parameter int AF_LEVEL  = 6,
    parameter int AE_LEVEL  = 2,
    parameter int FWFT      = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     w_data,
    input  logic                 write_en,
    input  logic                 read_en,
    input  logic                 clr_err,
    output logic [WIDTH-1:0]     r_data,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int DEPTH = 2 ** PTR_WIDTH;
    localparam logic [PTR_WIDTH:0] PTR_ONE = (PTR_WIDTH + 1)'(1);
    localparam logic [PTR_WIDTH:0] AF_THR  = (PTR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [PTR_WIDTH:0] AE_THR  = (PTR_WIDTH + 1)'(AE_LEVEL);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [PTR_WIDTH:0]   w_ptr_q, w_ptr_d;
    logic [PTR_WIDTH:0]   r_ptr_q, r_ptr_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;
    logic                 wr_acc, rd_acc;
    logic [PTR_WIDTH-1:0] w_addr, r_addr;

    assign w_addr = w_ptr_q[PTR_WIDTH-1:0];
    assign r_addr = r_ptr_q[PTR_WIDTH-1:0];

    // Status flags depend only on the pointer registers, never on the requests.
    assign empty        = (w_ptr_q == r_ptr_q);
    assign full         = (w_ptr_q[PTR_WIDTH] != r_ptr_q[PTR_WIDTH]) && (w_addr == r_addr);
    assign count        = w_ptr_q - r_ptr_q;
    assign almost_full  = (count >= AF_THR);
    assign almost_empty = (count <= AE_THR);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        wr_acc  = write_en && !full;
        rd_acc  = read_en && !empty;

        if (wr_acc) begin
            w_ptr_d = w_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            r_ptr_d = r_ptr_q + PTR_ONE;
        end

        // A new error event wins over a clear request in the same cycle.
        if (write_en && full) begin
            ovf_d = 1'b1;
        end else if (clr_err) begin
            ovf_d = 1'b0;
        end
        if (read_en && empty) begin
            udf_d = 1'b1;
        end else if (clr_err) begin
            udf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_acc) begin
            mem_q[w_addr] <= w_data;
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [WIDTH-1:0] rdata_q, rdata_d;

            always_comb begin
                rdata_d = rdata_q;
                if (rd_acc) begin
                    rdata_d = mem_q[r_addr];
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rdata_q <= '0;
                end else begin
                    rdata_q <= rdata_d;
                end
            end

            assign r_data = rdata_q;
        end else begin : g_fwft_read
            // Head word is shown directly; storage is reset so this is never X.
            assign r_data = mem_q[r_addr];
        end
    endgenerate

endmodule
